// File: rtl/bv_match_emitter.sv
// rtl/bv_match_emitter.sv - serial (index, priority) emitter for BV match vectors; optional feature macro PRIOR_FILTER_EN
module bv_match_emitter #(
    parameter int BV_WIDTH = 32,
    parameter int CNT_W    = $clog2(BV_WIDTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                bv_valid,
    input  logic [BV_WIDTH-1:0] bv_data,
    output logic                bv_ready,
    input  logic                cfg_wr,
    input  logic [7:0]          cfg_addr,
    input  logic [7:0]          cfg_prior,
    output logic                out_valid,
    output logic [7:0]          out_prior,
    output logic [7:0]          out_index,
    output logic                scan_done,
    output logic [CNT_W-1:0]    match_cnt
);

    localparam int IDX_W = $clog2(BV_WIDTH);

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_t;

    state_t              r_state;
    logic [BV_WIDTH-1:0] r_pending;
    logic [CNT_W-1:0]    r_cnt;
    logic [7:0]          r_table [BV_WIDTH];

    logic [IDX_W-1:0]    w_sel;
    logic [BV_WIDTH-1:0] w_lowbit;
    logic [BV_WIDTH-1:0] w_rest;
    logic [7:0]          w_sel_prior;
    logic                w_emit;
    logic                w_cfg_hit;

    assign bv_ready = (r_state == S_IDLE);

    // Isolate the lowest set bit; what remains after it is consumed decides the drain.
    assign w_lowbit    = r_pending & (~r_pending + BV_WIDTH'(1));
    assign w_rest      = r_pending & ~w_lowbit;
    assign w_sel_prior = r_table[w_sel];
    assign w_cfg_hit   = cfg_wr && (int'(cfg_addr) < BV_WIDTH);

`ifdef PRIOR_FILTER_EN
    // Priority 0 marks a disabled rule: it still takes its scan slot but is not emitted.
    assign w_emit = (w_sel_prior != 8'd0);
`else
    assign w_emit = 1'b1;
`endif

    // Priority encoder: index of the lowest set bit of the pending vector.
    always_comb begin
        w_sel = '0;
        for (int i = BV_WIDTH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel = IDX_W'(i);
            end
        end
    end

    // Priority table; a write landing on the entry being read shows up from the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BV_WIDTH; i++) begin
                r_table[i] <= 8'd0;
            end
        end else if (w_cfg_hit) begin
            r_table[cfg_addr[IDX_W-1:0]] <= cfg_prior;
        end
    end

    // Accept/scan FSM with registered tuple, drain pulse and final count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_cnt     <= '0;
            out_valid <= 1'b0;
            out_prior <= 8'd0;
            out_index <= 8'd0;
            scan_done <= 1'b0;
            match_cnt <= '0;
        end else begin
            out_valid <= 1'b0;
            scan_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bv_valid) begin
                        r_pending <= bv_data;
                        r_cnt     <= '0;
                        r_state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (r_pending == '0) begin
                        // Only reachable on the first scan cycle of an all-zero vector.
                        scan_done <= 1'b1;
                        match_cnt <= r_cnt;
                        r_state   <= S_IDLE;
                    end else begin
                        r_pending <= w_rest;
                        if (w_emit) begin
                            out_valid <= 1'b1;
                            out_index <= 8'(w_sel);
                            out_prior <= w_sel_prior;
                            r_cnt     <= r_cnt + CNT_W'(1);
                        end
                        if (w_rest == '0) begin
                            scan_done <= 1'b1;
                            match_cnt <= r_cnt + CNT_W'(w_emit);
                            r_state   <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
